// File: rtl/izh_tdm_scheduler.sv
// izh_tdm_scheduler: time-multiplexes one combinational Izhikevich integrator over N_NEURONS v/w state slots
module izh_tdm_scheduler #(
  parameter int WIDTH = 20,
  parameter int FR_WIDTH = 11,
  parameter int N_NEURONS = 8,
  parameter int IDX_W = 3,
  parameter int V_INIT = -65,
  parameter int W_INIT = -12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 clr,
  output logic [IDX_W-1:0]     cur_idx,
  input  logic [WIDTH-1:0]     cur_in,
  output logic [WIDTH-1:0]     int_I,
  output logic [WIDTH-1:0]     int_v_old,
  output logic [WIDTH-1:0]     int_w_old,
  input  logic [WIDTH-1:0]     int_v_new,
  input  logic [WIDTH-1:0]     int_w_new,
  input  logic                 int_fire,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes,
  output logic                 tick_miss,
  input  logic [IDX_W-1:0]     mon_idx,
  output logic [WIDTH-1:0]     mon_v
);
  localparam logic [WIDTH-1:0] V0 = WIDTH'(V_INIT * (2 ** FR_WIDTH));
  localparam logic [WIDTH-1:0] W0 = WIDTH'(W_INIT * (2 ** FR_WIDTH));
  localparam logic [IDX_W:0] NN = (IDX_W + 1)'(N_NEURONS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] v_q [N_NEURONS];
  logic [WIDTH-1:0] v_d [N_NEURONS];
  logic [WIDTH-1:0] w_q [N_NEURONS];
  logic [WIDTH-1:0] w_d [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q, acc_d, spikes_q, spikes_d;
  logic tick_miss_q, tick_miss_d;
  logic run, last;
  assign run = state_q == RUN;
  assign last = {1'b0, idx_q} == NN - 1'b1;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign spikes = spikes_q;
  assign tick_miss = tick_miss_q;
  assign cur_idx = run ? idx_q : '0;
  assign int_I = run ? cur_in : '0;
  assign int_v_old = run ? v_q[idx_q] : '0;
  assign int_w_old = run ? w_q[idx_q] : '0;
  assign mon_v = {1'b0, mon_idx} < NN ? v_q[mon_idx] : '0;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    v_d = v_q;
    w_d = w_q;
    acc_d = acc_q;
    spikes_d = spikes_q;
    tick_miss_d = tick && busy;
    if (state_q == IDLE && clr) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_d[i] = V0;
        w_d[i] = W0;
      end
      spikes_d = '0;
    end else if (state_q == IDLE && tick) begin
      state_d = RUN;
      idx_d = '0;
      acc_d = '0;
    end else if (run) begin
      v_d[idx_q] = int_v_new;
      w_d[idx_q] = int_w_new;
      acc_d[idx_q] = int_fire;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      spikes_d = acc_q;
      idx_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= V0;
        w_q[i] <= W0;
      end
      acc_q <= '0;
      spikes_q <= '0;
      tick_miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      v_q <= v_d;
      w_q <= w_d;
      acc_q <= acc_d;
      spikes_q <= spikes_d;
      tick_miss_q <= tick_miss_d;
    end
  end
endmodule
